// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction-fetch sequencer.
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: control, ROM and decode-handshake signals of the fetch sequencer.
`default_nettype none

interface fetch_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              start;
  logic              step;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_instr;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] pc_out;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halted;
  logic [15:0]       fetch_count;

  modport master (
    input  start, step, rom_instr, instr_ready, redirect_valid, redirect_pc,
    output rom_addr, instr_out, pc_out, instr_valid, halted, fetch_count
  );

  modport slave (
    output start, step, rom_instr, instr_ready, redirect_valid, redirect_pc,
    input  rom_addr, instr_out, pc_out, instr_valid, halted, fetch_count
  );

endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and one-entry fetch slot with run/step control,
// redirect squash, halt-sentinel detection and a saturating accept counter.
`default_nettype none

module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W    = 5,
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  HALT_WORD = HALT_WORD_DEFAULT,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
  input  wire                 clk,
  input  wire                 rst_n,
  fetch_sequencer_if.master   bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_STEP = STEP;
  localparam logic [1:0] S_HALT = HALT;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [15:0]       count_q, count_d;

  logic fetching;
  logic load_opp;
  logic is_halt;
  logic accept;

  always_comb begin
    fetching = (state_q == S_RUN) || (state_q == S_STEP);
    is_halt  = (bus.rom_instr == HALT_WORD);
    accept   = valid_q && bus.instr_ready && !bus.redirect_valid;
    load_opp = fetching && (!valid_q || bus.instr_ready) && !bus.redirect_valid;

    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    count_d  = (accept && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
        end else if (bus.step) begin
          state_d = S_STEP;
        end
      end
      S_HALT: begin
        if (bus.start) begin
          pc_d    = RESET_PC;
          state_d = S_RUN;
        end
      end
      S_RUN, S_STEP: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          valid_d = 1'b0;
        end else if ((state_q == S_STEP) && valid_q) begin
          // A step issues exactly one word: on its acceptance, go idle
          // rather than taking the load opportunity.
          if (bus.instr_ready) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end else if (load_opp) begin
          if (is_halt) begin
            valid_d = 1'b0;
            state_d = S_HALT;
          end else begin
            instr_d  = bus.rom_instr;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.fetch_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a stream/scoreboard model checked every cycle.
`default_nettype none

module tb_fetch_sequencer;

  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] rom0 [32];
  logic [31:0] rom1 [32];

  fetch_sequencer_if #(.ADDR_W(5), .DATA_W(32)) bus0 ();
  fetch_sequencer_if #(.ADDR_W(5), .DATA_W(32)) bus1 ();

  assign bus0.rom_instr = rom0[bus0.rom_addr];
  assign bus1.rom_instr = rom1[bus1.rom_addr];

  fetch_sequencer #(.ADDR_W(5), .DATA_W(32), .HALT_WORD(HW), .RESET_PC(5'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  fetch_sequencer #(.ADDR_W(5), .DATA_W(32), .HALT_WORD(HW), .RESET_PC(5'd31)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream model for dut0: the next issued word must come from the expected
  // PC, each accepted word is counted, and a stalled slot must not change.
  logic [4:0]  m_next_pc;
  int          m_count;
  logic        p_hold;
  logic [31:0] p_instr;
  logic [4:0]  p_pc;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_next_pc = 5'd0;
      m_count   = 0;
      p_hold    = 1'b0;
    end else begin
      chk("m_count", bus0.fetch_count, m_count);
      if (p_hold) begin
        chk("m_hold_valid", bus0.instr_valid, 1'b1);
        chk("m_hold_instr", bus0.instr_out, p_instr);
        chk("m_hold_pc", bus0.pc_out, p_pc);
      end
      if (bus0.instr_valid) begin
        chk("m_stream_pc", bus0.pc_out, m_next_pc);
        chk("m_stream_instr", bus0.instr_out, rom0[bus0.pc_out]);
        chk("m_pc_ahead", bus0.rom_addr, 5'(bus0.pc_out + 5'd1));
      end
      if (bus0.halted && !bus0.start)
        chk("m_halt_addr", bus0.rom_addr, m_next_pc);

      p_hold  = bus0.instr_valid && !bus0.instr_ready && !bus0.redirect_valid;
      p_instr = bus0.instr_out;
      p_pc    = bus0.pc_out;
      if (bus0.halted && bus0.start) begin
        m_next_pc = 5'd0;
      end else if (bus0.instr_valid && bus0.redirect_valid) begin
        m_next_pc = bus0.redirect_pc;
      end else if (bus0.instr_valid && bus0.instr_ready) begin
        m_next_pc = 5'(bus0.pc_out + 5'd1);
        m_count++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      rom0[i] = HW;
      rom1[i] = HW;
    end
    rom0[0] = 32'h01000093; rom0[1] = 32'h00102023; rom0[2] = 32'h00002183;
    rom0[3] = 32'h06418193; rom0[4] = 32'h003020a3; rom0[5] = 32'h00102203;
    rom1[31] = 32'h00000013; rom1[0] = 32'h01000093;

    rst_n = 1'b0;
    bus0.start = 0; bus0.step = 0; bus0.instr_ready = 0; bus0.redirect_valid = 0; bus0.redirect_pc = '0;
    bus1.start = 0; bus1.step = 0; bus1.instr_ready = 0; bus1.redirect_valid = 0; bus1.redirect_pc = '0;
    #12;
    chk("rst_valid", bus0.instr_valid, 1'b0);
    chk("rst_instr", bus0.instr_out, 32'h0);
    chk("rst_pc_out", bus0.pc_out, 5'd0);
    chk("rst_halted", bus0.halted, 1'b0);
    chk("rst_count", bus0.fetch_count, 16'd0);
    chk("rst_rom_addr", bus0.rom_addr, 5'd0);
    chk("rst_rom_addr1", bus1.rom_addr, 5'd31);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Run to halt with decode always ready.
    bus0.instr_ready = 1; bus0.start = 1;
    tick();
    bus0.start = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("run_valid", bus0.instr_valid, 1'b1);
      chk("run_pc", bus0.pc_out, 5'(i));
      if (i == 0) chk("run_first", bus0.instr_out, 32'h01000093);
      if (i == 5) chk("run_last", bus0.instr_out, 32'h00102203);
    end
    tick();
    chk("halt_halted", bus0.halted, 1'b1);
    chk("halt_valid", bus0.instr_valid, 1'b0);
    chk("halt_rom_addr", bus0.rom_addr, 5'd6);
    chk("halt_count", bus0.fetch_count, 16'd6);

    // Restart from halt, then stall decode on the second word.
    bus0.start = 1;
    tick();
    bus0.start = 0;
    tick();
    tick();
    chk("stall_pc0", bus0.pc_out, 5'd1);
    chk("stall_instr0", bus0.instr_out, 32'h00102023);
    bus0.instr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", bus0.instr_out, 32'h00102023);
      chk("stall_pc", bus0.pc_out, 5'd1);
      chk("stall_rom_addr", bus0.rom_addr, 5'd2);
    end
    bus0.instr_ready = 1;
    tick();
    chk("resume_instr", bus0.instr_out, 32'h00002183);
    chk("resume_pc", bus0.pc_out, 5'd2);
    chk("resume_count", bus0.fetch_count, 16'd8);

    // Asynchronous reset while the slot is full.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus0.instr_valid, 1'b0);
    chk("arst_rom_addr", bus0.rom_addr, 5'd0);
    chk("arst_count", bus0.fetch_count, 16'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_nofetch", bus0.instr_valid, 1'b0);
      chk("arst_pc_hold", bus0.rom_addr, 5'd0);
    end

    // Redirect squashes an unaccepted word.
    bus0.start = 1;
    tick();
    bus0.start = 0;
    tick();
    tick();
    bus0.instr_ready = 0;
    chk("redir_pre_pc", bus0.pc_out, 5'd1);
    tick();
    bus0.redirect_valid = 1; bus0.redirect_pc = 5'd4;
    tick();
    bus0.redirect_valid = 0;
    chk("redir_squash", bus0.instr_valid, 1'b0);
    chk("redir_rom_addr", bus0.rom_addr, 5'd4);
    chk("redir_count", bus0.fetch_count, 16'd1);
    tick();
    chk("redir_valid", bus0.instr_valid, 1'b1);
    chk("redir_pc", bus0.pc_out, 5'd4);
    chk("redir_instr", bus0.instr_out, 32'h003020a3);
    bus0.instr_ready = 1;
    tick();
    chk("redir_next_pc", bus0.pc_out, 5'd5);
    tick();
    chk("redir_halted", bus0.halted, 1'b1);
    chk("redir_final_count", bus0.fetch_count, 16'd3);

    // Single-step.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus0.instr_ready = 0; bus0.step = 1;
    tick();
    bus0.step = 0;
    chk("step_entry_valid", bus0.instr_valid, 1'b0);
    tick();
    chk("step1_valid", bus0.instr_valid, 1'b1);
    chk("step1_instr", bus0.instr_out, 32'h01000093);
    tick();
    chk("step1_hold_pc", bus0.pc_out, 5'd0);
    chk("step1_rom_addr", bus0.rom_addr, 5'd1);
    bus0.instr_ready = 1;
    tick();
    chk("step1_done", bus0.instr_valid, 1'b0);
    tick();
    tick();
    chk("step_idle_valid", bus0.instr_valid, 1'b0);
    chk("step_idle_pc", bus0.rom_addr, 5'd1);
    chk("step_idle_halted", bus0.halted, 1'b0);
    bus0.step = 1;
    tick();
    bus0.step = 0;
    tick();
    chk("step2_valid", bus0.instr_valid, 1'b1);
    chk("step2_instr", bus0.instr_out, 32'h00102023);
    chk("step2_pc", bus0.pc_out, 5'd1);
    tick();
    chk("step2_done", bus0.instr_valid, 1'b0);
    chk("step2_count", bus0.fetch_count, 16'd2);
    chk("step2_rom_addr", bus0.rom_addr, 5'd2);

    // PC wrap from a non-zero reset address.
    bus1.instr_ready = 1; bus1.start = 1;
    tick();
    bus1.start = 0;
    tick();
    chk("wrap_pc31", bus1.pc_out, 5'd31);
    chk("wrap_instr31", bus1.instr_out, 32'h00000013);
    tick();
    chk("wrap_pc0", bus1.pc_out, 5'd0);
    chk("wrap_instr0", bus1.instr_out, 32'h01000093);
    tick();
    chk("wrap_halted", bus1.halted, 1'b1);
    chk("wrap_rom_addr", bus1.rom_addr, 5'd1);
    chk("wrap_count", bus1.fetch_count, 16'd2);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the single-cycle core. It owns the program counter, drives the address of the combinational instruction ROM, and registers each fetched word into a one-entry output slot with a valid/ready handshake toward decode. It also provides run/single-step control, branch/jump redirect with squash, halt detection on the halt sentinel, and an accepted-instruction counter.

## Interface
- ADDR_W, 5, ROM word-address width; PC is a word index.
- DATA_W, 32, instruction width.
- HALT_WORD, 32'hFFFF_FFFF, sentinel that stops fetch.
- RESET_PC, 0, PC value after reset.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: IDLE/HALT → RUN.
- step  in  1  pulse: IDLE → STEP (issue one instruction).
- rom_addr  out  ADDR_W  ROM address; always equals PC register.
- rom_instr  in  DATA_W  ROM data, combinational from rom_addr.
- instr_out  out  DATA_W  registered instruction.
- pc_out  out  ADDR_W  address of instr_out.
- instr_valid  out  1  instr_out/pc_out valid.
- instr_ready  in  1  decode accepts this cycle.
- redirect_valid  in  1  load redirect_pc, squash slot.
- redirect_pc  in  ADDR_W  redirect target.
- halted  out  1  high in HALT.
- fetch_count  out  16  accepted instructions, saturating.

## Operation
- States: IDLE, RUN, STEP, HALT. Reset: IDLE, PC=RESET_PC, instr_out=0, pc_out=0, instr_valid=0, halted=0, fetch_count=0.
- IDLE: no fetch. start → RUN; step → STEP; start wins if both are asserted.
- Load opportunity (RUN/STEP): (!instr_valid || instr_ready) && !redirect_valid.
- At a load opportunity, if rom_instr != HALT_WORD: instr_out←rom_instr, pc_out←PC, instr_valid←1, PC←PC+1 mod 2^ADDR_W.
- At a load opportunity, if rom_instr == HALT_WORD: halt word is never issued; instr_valid←0; PC unchanged; state←HALT.
- Slot full and instr_ready=0: instr_out, pc_out and PC hold.
- STEP: exactly one load. Return to IDLE on the cycle that instruction is accepted. If the word is HALT_WORD, go to HALT instead.
- Redirect (RUN/STEP only): PC←redirect_pc, instr_valid←0, whether or not instr_ready is high that cycle. An instruction squashed this way is not counted. Fetch resumes next cycle. Redirect in IDLE/HALT is ignored.
- HALT: halted=1, rom_addr holds the halt address. start → PC←RESET_PC, RUN. step is ignored.
- fetch_count increments when instr_valid && instr_ready && !redirect_valid, and saturates at 16'hFFFF.

## Timing
- start sampled at edge E0 → RUN after E0. rom[PC] is captured at E1 → instr_valid high after E1 (1-cycle latency).
- With instr_ready held at 1, the block sustains one instruction per cycle.
- Halt: halted rises one edge after the halt word appears on rom_instr at a load opportunity.
- Redirect at edge Er: target instruction is valid after Er+1.
- Outputs are registered except rom_addr, which comes directly from the PC flop.
- Reset mid-operation: all state clears immediately (asynchronous). First fetch requires a new start/step after rst_n deasserts.

## Structure
- Shared package fetch_pkg: fetch_state_t enum (IDLE, RUN, STEP, HALT) and the HALT_WORD default constant.
- Single module, no sub-module. The output slot is a one-entry register inline with the FSM.

## Test plan
- ROM = {0:01000093, 1:00102023, 2:00002183, 3:06418193, 4:003020a3, 5:00102203, 6+:FFFFFFFF}; start, ready=1 → six valid beats on consecutive cycles with pc_out 0..5; then halted=1, rom_addr=6, fetch_count=6.
- Same ROM, instr_ready=0 for 3 cycles while instr_out=00102023 → instr_out and pc_out=1 stable; PC stays 2; resume gives 00002183 next.
- Redirect_pc=4 while slot holds pc_out=1 unaccepted → slot squashed; next valid is 003020a3, pc_out=4; fetch_count excludes the squashed word.
- step from IDLE → exactly one beat 01000093, then IDLE with PC=1; a second step → 00102023.
- RESET_PC=31, rom[31]=00000013, rom[0]=01000093 → beats pc_out=31 then pc_out=0 (wrap).
- rst_n low mid-RUN with a valid slot → instr_valid=0, PC=RESET_PC immediately; no fetch until the next start.
